// File: rtl/snn_cfg_pkg.sv
// Shared constants for the SNN configuration loader: frame headers, FSM states
// and the weight/delay vector width helpers used by the loader and the SNN core.
package snn_cfg_pkg;

    localparam logic [7:0] HDR_WEIGHTS = 8'h01;
    localparam logic [7:0] HDR_DELAYS  = 8'h02;
    localparam logic [7:0] HDR_PARAMS  = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_e;

    function automatic int syn_count(input int n_in, input int n_hid, input int n_out);
        return n_in * n_hid + n_hid * n_out;
    endfunction

    function automatic int ww_f(input int n_in, input int n_hid, input int n_out, input int nbits);
        return syn_count(n_in, n_hid, n_out) * nbits;
    endfunction

    function automatic int dw_f(input int n_in, input int n_hid, input int n_out, input int dbits);
        return syn_count(n_in, n_hid, n_out) * dbits;
    endfunction

endpackage

// File: rtl/snn_config_loader.sv
// Byte-stream loader for SNN weights, delays and neuron parameters.
// Latency: last payload byte at cycle N -> outputs and cfg_update at N+1.
// Backpressure: data_ready drops only for the single COMMIT cycle and during reset.
module snn_config_loader
    import snn_cfg_pkg::*;
#(
    parameter int NBITS = 2,
    parameter int N_IN  = 24,
    parameter int N_HID = 8,
    parameter int N_OUT = 2,
    parameter int DBITS = 4,
    localparam int WW   = ww_f(N_IN, N_HID, N_OUT, NBITS),
    localparam int DW   = dw_f(N_IN, N_HID, N_OUT, DBITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             abort,
    output logic [WW-1:0]    weights,
    output logic [DW-1:0]    delays,
    output logic [NBITS-1:0] threshold,
    output logic [NBITS-1:0] decay,
    output logic [NBITS-1:0] refractory_period,
    output logic             busy,
    output logic             cfg_update,
    output logic             err
);

    localparam int CW = $clog2(DW / 8) + 1;
    localparam logic [CW-1:0] LAST_W = CW'(WW / 8 - 1);
    localparam logic [CW-1:0] LAST_D = CW'(DW / 8 - 1);

    cfg_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       hdr_q, hdr_d;
    logic [DW-1:0]    stg_q, stg_d;
    logic [WW-1:0]    weights_q, weights_d;
    logic [DW-1:0]    delays_q, delays_d;
    logic [NBITS-1:0] thr_q, thr_d;
    logic [NBITS-1:0] dec_q, dec_d;
    logic [NBITS-1:0] ref_q, ref_d;
    logic             err_q, err_d;
    logic [CW-1:0]    last_idx;
    logic             xfer;
    logic             hdr_known;

    assign data_ready = !reset && (state_q != ST_COMMIT);
    assign xfer       = data_valid && data_ready;
    assign hdr_known  = (data_in == HDR_WEIGHTS) || (data_in == HDR_DELAYS) ||
                        (data_in == HDR_PARAMS);

    always_comb begin
        last_idx = '0;
        case (hdr_q)
            HDR_WEIGHTS: last_idx = LAST_W;
            HDR_DELAYS:  last_idx = LAST_D;
            default:     last_idx = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        stg_d     = stg_q;
        weights_d = weights_q;
        delays_d  = delays_q;
        thr_d     = thr_q;
        dec_d     = dec_q;
        ref_d     = ref_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (hdr_known) begin
                        hdr_d   = data_in;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    stg_d[8*int'(cnt_q) +: 8] = data_in;
                    cnt_d = cnt_q + 1'b1;
                    // Active registers load on the same edge that enters COMMIT so the
                    // new values are visible alongside the cfg_update pulse.
                    if (cnt_q == last_idx) begin
                        state_d = ST_COMMIT;
                        case (hdr_q)
                            HDR_WEIGHTS: weights_d = stg_d[WW-1:0];
                            HDR_DELAYS:  delays_d  = stg_d;
                            default: begin
                                thr_d = stg_d[NBITS-1:0];
                                dec_d = stg_d[2*NBITS-1:NBITS];
                                ref_d = stg_d[3*NBITS-1:2*NBITS];
                            end
                        endcase
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hdr_q     <= '0;
            stg_q     <= '0;
            weights_q <= '0;
            delays_q  <= '0;
            thr_q     <= '0;
            dec_q     <= '0;
            ref_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            stg_q     <= stg_d;
            weights_q <= weights_d;
            delays_q  <= delays_d;
            thr_q     <= thr_d;
            dec_q     <= dec_d;
            ref_q     <= ref_d;
            err_q     <= err_d;
        end
    end

    assign weights           = weights_q;
    assign delays            = delays_q;
    assign threshold         = thr_q;
    assign decay             = dec_q;
    assign refractory_period = ref_q;
    assign err               = err_q;
    assign busy              = (state_q != ST_IDLE);
    assign cfg_update        = (state_q == ST_COMMIT);

endmodule

// File: doc/snn_config_loader.md
SNN_CONFIG_LOADER -- requirements
Module: snn_config_loader

Interface
REQ-001 Parameter NBITS, default 2, weight/threshold/decay/refractory field width.
REQ-002 Parameter N_IN, default 24, input spikes; N_HID, default 8, hidden neurons; N_OUT, default 2, output neurons.
REQ-003 Parameter DBITS, default 4, bits per synaptic delay.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_in  input  8  configuration byte stream.
REQ-007 data_valid  input  1  data_in holds a valid byte.
REQ-008 data_ready  output  1  loader accepts a byte this cycle.
REQ-009 abort  input  1  discard the frame in progress.
REQ-010 weights  output  WW=(N_IN*N_HID+N_HID*N_OUT)*NBITS  active weight vector (416 at defaults).
REQ-011 delays  output  DW=(N_IN*N_HID+N_HID*N_OUT)*DBITS  active delay vector (832 at defaults).
REQ-012 threshold, decay, refractory_period  output  NBITS each  active neuron parameters.
REQ-013 busy  output  1  high in RECV and COMMIT.
REQ-014 cfg_update  output  1  one-cycle pulse when active outputs change.
REQ-015 err  output  1  sticky; set on unknown header, cleared by reset or next valid header.

Function
REQ-016 Transfer occurs only in a cycle with data_valid and data_ready both high.
REQ-017 Frame = 1 header byte then payload; header 0x01 weights (WW/8 = 52 bytes), 0x02 delays (DW/8 = 104 bytes), 0x03 params (1 byte).
REQ-018 Params byte: bits[1:0] threshold, [3:2] decay, [5:4] refractory_period, [7:6] ignored (NBITS=2 mapping).
REQ-019 FSM states IDLE, RECV, COMMIT; reset state IDLE.
REQ-020 IDLE: valid known header latches target, clears byte counter, clears err, goes to RECV.
REQ-021 IDLE: unknown header sets err, stays in IDLE, no other state change.
REQ-022 RECV: payload byte k (k from 0) writes staging bits [8k+7:8k]; counter increments per transfer.
REQ-023 RECV: transfer of last payload byte (k = length-1) moves to COMMIT next cycle.
REQ-024 COMMIT lasts exactly one cycle: staging copied to the target active output(s), cfg_update high that cycle, then IDLE.
REQ-025 Active outputs change only in COMMIT; non-target outputs hold their values.
REQ-026 data_ready high in IDLE and RECV, low in COMMIT and while reset is asserted.
REQ-027 abort in RECV: return to IDLE next cycle, byte in same cycle discarded, active outputs unchanged, no cfg_update.
REQ-028 abort in IDLE or COMMIT has no effect; a COMMIT in progress completes.
REQ-029 Latency: last payload transfer at cycle N -> new values visible and cfg_update at cycle N+1.
REQ-030 Back-to-back frames: a header is accepted in the cycle after COMMIT with no extra idle cycle.
REQ-031 Byte counter width ceil(log2(DW/8)) + 1, never wraps within a frame.

Reset
REQ-032 On reset: state IDLE, counter 0, staging 0, weights 0, delays 0, threshold 0, decay 0, refractory_period 0, busy 0, cfg_update 0, err 0.
REQ-033 Reset mid-frame discards staging; no partial configuration ever appears on outputs.

Structure
REQ-034 Shared package snn_cfg_pkg holds header constants (0x01/0x02/0x03), FSM state enum, and WW/DW width functions.
REQ-035 Single module, no sub-modules; staging register sized DW, shared by all targets.
REQ-036 Outputs connect directly to the weights, delays, threshold, decay, refractory_period ports of SNNwithDelays_top.

Verification
REQ-037 Reset then header 0x03, byte 0x39 -> next cycle after payload: threshold=1, decay=2, refractory_period=3, cfg_update pulse, weights/delays still 0.
REQ-038 Header 0x01 + 52 bytes 0x00..0x33 -> weights[7:0]=0x00, weights[415:408]=0x33, cfg_update one cycle, delays unchanged.
REQ-039 Header 0x02, 50 bytes, abort -> state IDLE, delays unchanged, no cfg_update; subsequent full 104-byte frame of 0xAA -> delays all 0xAA.
REQ-040 Header 0x7F -> err=1, busy=0; then header 0x03 + 0x00 -> err=0, params updated.
REQ-041 data_valid held high across two frames -> data_ready low exactly during COMMIT, no byte lost, second frame committed correctly.
REQ-042 Reset asserted after 20 weight bytes -> all outputs 0; next complete frame loads correctly.
